proc_seq_ctrl: RTL and testbench
================================

Name: proc_seq_ctrl

Overview:
Multi-cycle control sequencer for the 8-bit processor core. It fetches instruction bytes from instruction memory and holds them in an instruction register that feeds the instruction decoder. It uses the decoded opcode to step through decode, immediate fetch, data-memory access, execute and writeback. It owns the program counter and generates all one-cycle strobes for the ALU, register file and data memory.

Parameters:
PC_W, 8, program counter / instruction address width
RST_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution from IDLE; ignored in all other states
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (equals pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  8  fetched byte
ir_out  out  8  instruction register, drives decoder instruction input
opcode_in  in  4  decoder opcode output (combinational from ir_out)
imm_out  out  8  latched immediate byte
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
dmem_ack  in  1  data memory access complete
alu_en  out  1  one-cycle execute strobe
reg_we  out  1  one-cycle register-file write strobe
halted  out  1  core stopped on HALT
state_out  out  3  current state encoding, for debug

Behaviour:
- Reset: rst_n low asynchronously forces the following values, held while low:
  - state = IDLE; pc = RST_PC; ir_out = 0; imm_out = 0.
  - All strobes and requests = 0; halted = 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, FETCH_IMM=3, MEM=4, EXEC=5, WB=6, HALT=7.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, held until ack.
  - imem_ack=1 on a clock edge: ir_out <= imem_rdata, pc <= pc+1, go to DECODE.
  - ack may arrive in the same cycle as req; no ack -> stay in FETCH.
- DECODE (1 cycle, uses opcode_in):
  - 0000 (NOP) -> FETCH.
  - 0010 (LDI) or 0011 (ADDI) -> FETCH_IMM.
  - 0100 (LD) or 0101 (ST) -> MEM.
  - 1111 (HALT) -> HALT.
  - Any other opcode -> EXEC.
- FETCH_IMM: same handshake as FETCH; on ack, imm_out <= imem_rdata, pc <= pc+1, go to EXEC.
- MEM:
  - dmem_req=1, with dmem_we=1 for opcode 0101 and 0 for 0100, held until dmem_ack.
  - On ack: LD -> WB; ST -> FETCH (no writeback).
- EXEC: alu_en=1 for exactly one cycle -> WB.
- WB: reg_we=1 for exactly one cycle -> FETCH.
- HALT: halted=1, all requests and strobes 0, pc frozen. Exit is by reset only; start is ignored.
- PC arithmetic: modulo 2^PC_W; with PC_W=8, 0xFF increments to 0x00 with no flag.
- Strobe encoding: alu_en, reg_we, imem_req and dmem_req are Moore outputs decoded from state.
- Spurious handshakes: imem_ack outside FETCH/FETCH_IMM and dmem_ack outside MEM are ignored and change nothing.
- imm_out: holds its last value until the next FETCH_IMM capture, so it is stale for non-immediate instructions.
- Cycle counts, with ack in the same cycle as req:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDI/ADDI: 5 cycles.
  - LD: 4 cycles.
  - ST: 3 cycles.
  - NOP: 2 cycles.
  - Each wait cycle on an ack adds 1 cycle.
- Reset mid-operation: an in-flight request is dropped immediately (combinational deassert via state). No partial ir/pc update is retained.

Test Plan:
- Reset then start, imem returns 0x15 (ALU op 0001) with immediate ack -> states 1,2,5,6,1; alu_en then reg_we each high 1 cycle; pc 0->1; ir_out=0x15.
- Program 0x2A, 0x7E (LDI + immediate) -> FETCH_IMM taken; imm_out=0x7E; pc=2; reg_we pulses once; total 5 cycles.
- ST 0x50 with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=1 held for 4 cycles; next state FETCH; reg_we never asserted. LD 0x40 -> dmem_we=0, then WB.
- imem_ack held low 5 cycles in FETCH -> imem_req stays high, imem_addr stable, state stays 1. Spurious dmem_ack pulse during FETCH -> no effect.
- Preload pc=0xFF (reset with RST_PC=0xFF), fetch 0x00 NOP -> pc wraps to 0x00; DECODE goes straight to FETCH.
- Fetch 0xF0 -> halted=1, state 7, further start/ack ignored; rst_n pulsed low mid-FETCH of a later run -> all outputs zero within the same cycle, pc=RST_PC.

Source files
------------

// File: rtl/proc_seq_ctrl.sv
// Multi-cycle control sequencer for the 8-bit core: instruction fetch,
// decode dispatch, immediate fetch, data-memory access, execute, writeback.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  IDLE      | waiting for start
//  FETCH     | imem request at pc, capture opcode byte on ack
//  DECODE    | one cycle, dispatch on decoder opcode
//  FETCH_IMM | imem request at pc, capture immediate on ack
//  MEM       | dmem request (store for ST, load for LD)
//  EXEC      | one-cycle ALU strobe
//  WB        | one-cycle register-file write strobe
//  HALT      | stopped until reset
module proc_seq_ctrl #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic [7:0]      ir_out,
    input  logic [3:0]      opcode_in,
    output logic [7:0]      imm_out,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            alu_en,
    output logic            reg_we,
    output logic            halted,
    output logic [2:0]      state_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_MEM       = 3'd4,
        S_EXEC      = 3'd5,
        S_WB        = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LDI  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore strobes; ir_out is stable through MEM so
    // the decoder opcode still tells LD from ST there.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_en    = 1'b0;
        reg_we    = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_in)
                    OP_NOP:          state_nxt = S_FETCH;
                    OP_LDI, OP_ADDI: state_nxt = S_FETCH_IMM;
                    OP_LD, OP_ST:    state_nxt = S_MEM;
                    OP_HALT:         state_nxt = S_HALT;
                    default:         state_nxt = S_EXEC;
                endcase
            end
            S_FETCH_IMM: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = S_EXEC;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode_in == OP_ST);
                if (dmem_ack) state_nxt = (opcode_in == OP_ST) ? S_FETCH : S_WB;
            end
            S_EXEC: begin
                alu_en    = 1'b1;
                state_nxt = S_WB;
            end
            S_WB: begin
                reg_we    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Program counter, instruction and immediate capture on fetch handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RST_PC;
            ir_out  <= 8'h00;
            imm_out <= 8'h00;
        end else if (imem_ack) begin
            if (state == S_FETCH) begin
                ir_out <= imem_rdata;
                pc     <= pc + PC_ONE;
            end else if (state == S_FETCH_IMM) begin
                imm_out <= imem_rdata;
                pc      <= pc + PC_ONE;
            end
        end
    end

    assign imem_addr = pc;
    assign state_out = state;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Bench for proc_seq_ctrl: directed instruction sequences, with per-cycle
// expected observations queued by the stimulus and checked by a monitor.
module tb_proc_seq_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic [7:0] addr;
        logic       dreq;
        logic       dwe;
        logic       alu;
        logic       rwe;
        logic       hlt;
        logic [7:0] ir;
        logic [7:0] imm;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_w = 1'b0;
    logic       start = 1'b0;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       dmem_ack = 1'b0;
    logic       sel = 1'b0;

    logic       imem_req, dmem_req, dmem_we, alu_en, reg_we, halted;
    logic [7:0] imem_addr, ir_out, imm_out;
    logic [3:0] opcode_in;
    logic [2:0] state_out;

    logic       w_imem_req, w_dmem_req, w_dmem_we, w_alu_en, w_reg_we, w_halted;
    logic [7:0] w_imem_addr, w_ir_out, w_imm_out;
    logic [3:0] w_opcode_in;
    logic [2:0] w_state_out;

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;

    obs_t exp_q[$];
    logic [7:0] m_pc, m_ir, m_imm;

    always #5 clk = ~clk;

    assign opcode_in   = ir_out[7:4];
    assign w_opcode_in = w_ir_out[7:4];

    proc_seq_ctrl #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_out(ir_out), .opcode_in(opcode_in),
        .imm_out(imm_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .alu_en(alu_en), .reg_we(reg_we),
        .halted(halted), .state_out(state_out)
    );

    proc_seq_ctrl #(.PC_W(8), .RST_PC(8'hFF)) dut_w (
        .clk(clk), .rst_n(rst_w), .start(start),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_out(w_ir_out), .opcode_in(w_opcode_in),
        .imm_out(w_imm_out), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
        .dmem_ack(dmem_ack), .alu_en(w_alu_en), .reg_we(w_reg_we),
        .halted(w_halted), .state_out(w_state_out)
    );

    obs_t obs_main, obs_wrap;
    assign obs_main = {state_out, imem_req, imem_addr, dmem_req, dmem_we,
                       alu_en, reg_we, halted, ir_out, imm_out};
    assign obs_wrap = {w_state_out, w_imem_req, w_imem_addr, w_dmem_req, w_dmem_we,
                       w_alu_en, w_reg_we, w_halted, w_ir_out, w_imm_out};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops one expected observation per cycle the stimulus queued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            cyc_no++;
            chk($sformatf("cycle%0d(st/ireq/addr/dreq/dwe/alu/rwe/hlt/ir/imm)", cyc_no),
                64'(sel ? obs_wrap : obs_main), 64'(e));
        end
    end

    // One clock of stimulus; st is the hand-derived state for this cycle
    task automatic step(input logic [2:0] st, input logic ia, input logic [7:0] rd,
                        input logic da, input logic s);
        obs_t e;
        e.st   = st;
        e.ireq = (st == 3'd1) || (st == 3'd3);
        e.addr = m_pc;
        e.dreq = (st == 3'd4);
        e.dwe  = (st == 3'd4) && (m_ir[7:4] == 4'b0101);
        e.alu  = (st == 3'd5);
        e.rwe  = (st == 3'd6);
        e.hlt  = (st == 3'd7);
        e.ir   = m_ir;
        e.imm  = m_imm;
        exp_q.push_back(e);
        imem_ack   = ia;
        imem_rdata = rd;
        dmem_ack   = da;
        start      = s;
        @(posedge clk);
        #2;
        if (ia && st == 3'd1) begin m_ir = rd;  m_pc = m_pc + 8'd1; end
        if (ia && st == 3'd3) begin m_imm = rd; m_pc = m_pc + 8'd1; end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        m_pc = 8'h00; m_ir = 8'h00; m_imm = 8'h00;
        @(posedge clk); #2;
        // reset held: acks and start must not matter
        step(3'd0, 1'b1, 8'h15, 1'b1, 1'b1);
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        // ALU op 0x15, spurious imem_ack in DECODE
        step(3'd1, 1'b1, 8'h15, 1'b0, 1'b0);
        step(3'd2, 1'b1, 8'hAA, 1'b1, 1'b0);
        step(3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd6, 1'b1, 8'hBB, 1'b0, 1'b0);
        // LDI 0x2A, imm 0x7E
        step(3'd1, 1'b1, 8'h2A, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd3, 1'b1, 8'h7E, 1'b0, 1'b0);
        step(3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd6, 1'b0, 8'h00, 1'b0, 1'b0);
        // FETCH stall 5 cycles, spurious dmem_ack inside it
        step(3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(3'd1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        // ST 0x50, dmem_ack delayed 3 cycles, spurious imem_ack in MEM
        step(3'd1, 1'b1, 8'h50, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd4, 1'b1, 8'hCC, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
        // LD 0x40, immediate ack; imm_out stays stale at 0x7E
        step(3'd1, 1'b1, 8'h40, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
        step(3'd6, 1'b0, 8'h00, 1'b0, 1'b0);
        // NOP
        step(3'd1, 1'b1, 8'h00, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        // HALT 0xF0, then start/acks ignored, pc frozen
        step(3'd1, 1'b1, 8'hF0, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd7, 1'b1, 8'h11, 1'b1, 1'b1);
        step(3'd7, 1'b1, 8'h22, 1'b0, 1'b0);
        step(3'd7, 1'b0, 8'h00, 1'b1, 1'b1);
        // reset, new run, LDI then reset asserted in the middle of FETCH
        rst_n = 1'b0;
        m_pc = 8'h00; m_ir = 8'h00; m_imm = 8'h00;
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(3'd1, 1'b1, 8'h3A, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd3, 1'b1, 8'h33, 1'b0, 1'b0);
        step(3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd6, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = 8'h99;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 64'(state_out), 64'd0);
        chk("async_rst_imem_req", 64'(imem_req), 64'd0);
        chk("async_rst_pc", 64'(imem_addr), 64'h00);
        chk("async_rst_ir", 64'(ir_out), 64'h00);
        chk("async_rst_imm", 64'(imm_out), 64'h00);
        chk("async_rst_strobes", 64'({dmem_req, dmem_we, alu_en, reg_we, halted}), 64'd0);
        @(posedge clk); #2;
        imem_ack = 1'b0;
        // pc wrap on the RST_PC=0xFF instance
        sel = 1'b1;
        m_pc = 8'hFF; m_ir = 8'h00; m_imm = 8'h00;
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_w = 1'b1;
        step(3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(3'd1, 1'b1, 8'h00, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(3'd1, 1'b1, 8'h15, 1'b0, 1'b0);
        step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
